// File: rtl/led_pwm_fader_if.sv
// Signal bundle between the LED control logic and the PWM fader.
// The master drives the LED requests and brightness target.
// The slave (the fader) returns the PWM drive and the frame pulse.
interface led_pwm_fader_if;
  logic [7:0] led_in;
  logic [7:0] brightness;
  logic [7:0] led_out;
  logic       frame_tick;

  modport master (
    output led_in,
    output brightness,
    input  led_out,
    input  frame_tick
  );

  modport slave (
    input  led_in,
    input  brightness,
    output led_out,
    output frame_tick
  );
endinterface

// File: rtl/led_pwm_fader.sv
// Eight-channel LED PWM driver with per-frame brightness fading.
// A prescaler divides clk into PWM ticks, and an 8-bit counter sweeps each frame.
// At every frame boundary each channel level steps toward its target by at most STEP.
module led_pwm_fader #(
  parameter int PRESCALE = 4,
  parameter int STEP     = 8
) (
  input  logic           clk,
  input  logic           nrst,
  led_pwm_fader_if.slave bus
);

  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
  localparam logic [8:0]  STEP_W   = 9'(STEP);

  logic [15:0] psc;
  logic [7:0]  pwm_cnt;
  logic        pwm_tick;
  logic        frame_event;
  logic [7:0]  level      [8];
  logic [7:0]  level_next [8];
  logic [7:0]  led_out_q;
  logic        frame_tick_q;

  assign pwm_tick    = (psc == PSC_LAST);
  assign frame_event = pwm_tick && (pwm_cnt == 8'd255);

  assign bus.led_out    = led_out_q;
  assign bus.frame_tick = frame_tick_q;

  // Move one level toward its target by at most STEP, clamping at the target.
  // The 9-bit working width keeps the sum and difference from wrapping.
  function automatic logic [7:0] fade_step(input logic [7:0] lvl, input logic [7:0] tgt);
    logic [8:0] l9;
    logic [8:0] t9;
    logic [8:0] s9;
    logic [7:0] r;
    l9 = {1'b0, lvl};
    t9 = {1'b0, tgt};
    s9 = l9 + STEP_W;
    r  = lvl;
    if (l9 < t9) begin
      r = (s9 > t9) ? tgt : s9[7:0];
    end else if (l9 > t9) begin
      r = ((l9 - t9) <= STEP_W) ? tgt : 8'(l9 - STEP_W);
    end
    return r;
  endfunction

  // Prescaler and PWM counter; the counter advances once per PWM tick.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      psc     <= '0;
      pwm_cnt <= '0;
    end else begin
      psc <= pwm_tick ? 16'd0 : psc + 16'd1;
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  // Next level per channel: step toward brightness (lit) or zero (unlit) on a frame event.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_next[i] = level[i];
      if (frame_event) begin
        level_next[i] = fade_step(level[i], bus.led_in[i] ? bus.brightness : 8'd0);
      end
    end
  end

  // Level state, registered PWM compare and registered frame pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 8; i++) begin
        level[i] <= '0;
      end
      led_out_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        level[i]     <= level_next[i];
        led_out_q[i] <= (pwm_cnt < level[i]);
      end
      frame_tick_q <= frame_event;
    end
  end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and nrst; all state changes on rising clk.
REQ-002 Parameter PRESCALE, default 4: clk cycles per PWM tick; legal range 1..65535.
REQ-003 Parameter STEP, default 8: maximum level change per channel per frame; legal range 1..255.
REQ-004 Port clk  input  1  system clock; 6 ns nominal period.
REQ-005 Port nrst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 Port led_in  input  8  on/off request per LED, driven by the led output of the principal block.
REQ-007 Port brightness  input  8  target level for lit channels, 0..255.
REQ-008 Port led_out  output  8  registered PWM drive to the physical LEDs.
REQ-009 Port frame_tick  output  1  one-cycle pulse at each PWM frame boundary.

Function
REQ-010 Prescaler psc SHALL count 0..PRESCALE-1 and wrap to 0; pwm_tick = (psc == PRESCALE-1), combinational and internal; with PRESCALE=1, pwm_tick SHALL be 1 every cycle.
REQ-011 8-bit pwm_cnt SHALL increment on pwm_tick, wrapping from 255 to 0; otherwise it SHALL hold.
REQ-012 frame event = pwm_tick AND pwm_cnt == 255; frame_tick SHALL be registered and high for exactly the one cycle after each frame event.
REQ-013 Frame period SHALL be exactly 256*PRESCALE clk cycles.
REQ-014 Each channel i SHALL hold an 8-bit level[i]; per-channel target[i] = brightness if led_in[i]=1, else 0, with led_in and brightness sampled in the frame-event cycle.
REQ-015 On a frame event: if level < target, level SHALL become min(level+STEP, target); if level > target, it SHALL become max(level-STEP, target); if equal, it SHALL hold.
REQ-016 Level arithmetic SHALL be at least 9 bits wide internally, so no wrap-around occurs; for example, 192+64 with target 255 SHALL give 255, not 0.
REQ-017 Levels SHALL change only on frame events; led_in and brightness changes between frame events SHALL have no effect until the next frame event.
REQ-018 Every cycle, led_out[i] SHALL be registered from (pwm_cnt < level[i]), giving one clk of latency from the counter and level state.
REQ-019 level 0 SHALL give led_out[i] constantly 0; level L SHALL give exactly L high pwm_cnt values per frame; level 255 SHALL give a duty of 255/256.
REQ-020 A simultaneous change of brightness and led_in in the frame-event cycle SHALL use the new values for that update.
REQ-021 All eight channels SHALL update in the same cycle, independently of each other.

Reset
REQ-022 When nrst=0 at a rising clk, psc, pwm_cnt, all levels, led_out and frame_tick SHALL be 0 after that edge.
REQ-023 Reset SHALL take priority over every update, including a frame event in the same cycle.
REQ-024 After nrst returns to 1, the first pwm_tick SHALL occur PRESCALE cycles later, and the first frame_tick exactly 256*PRESCALE+1 cycles later.
REQ-025 Reset asserted mid-fade SHALL discard fade state; levels SHALL restart from 0.

Verification
REQ-026 Reset scenario: run the design, assert nrst=0 for one cycle mid-frame -> next cycle led_out=0x00, frame_tick=0, and the frame period restarts per REQ-024.
REQ-027 Fade-up scenario (PRESCALE=1, STEP=64): led_in=0x01, brightness=255 -> level[0] after successive frames is 64, 128, 192, 255, then holds; other channels stay 0.
REQ-028 Fade-down scenario: from level[0]=255, led_in=0x00 -> levels 191, 127, 63, 0; led_out[0] constantly 0 after the last frame.
REQ-029 Brightness-drop scenario: led_in=0xFF at level 255, brightness set to 100 -> all channels go 191, 127, 100, then hold at 100.
REQ-030 Duty scenario: steady level 128 -> exactly 128 of 256 pwm ticks have led_out high per frame, high ticks contiguous from pwm_cnt 0..127 (offset by one clk).
REQ-031 Period scenario (PRESCALE=4): frame_tick pulses are exactly 1024 cycles apart, each one cycle wide.
